prga_enc: RTL and testbench
===========================

Name: prga_enc

Overview:
ARC4 keystream encryptor. It is the transmit-side counterpart of the PRGA decryptor and runs after KSA has initialised S.
- Reads a length-prefixed plaintext from PT memory (pt[0] = L, pt[1..L] = message).
- Generates the ARC4 keystream from S memory, swapping S as it goes.
- Writes a length-prefixed ciphertext to CT memory: ct[0] = L, ct[k] = pt[k] ^ pad[k].
- Sits between the KSA block and the S/PT/CT on-chip RAMs under the top-level controller's en/rdy handshake.

Parameters:
PT_BASE, 0, base address of the length-prefixed plaintext in PT memory (8-bit address space).
CT_BASE, 0, base address of the length-prefixed ciphertext in CT memory (8-bit address space).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  start request; accepted only on a cycle where rdy=1
rdy  output  1  high when idle and able to accept en
s_addr  output  8  S memory address
s_rddata  input  8  S memory read data
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable
pt_addr  output  8  plaintext memory address
pt_rddata  input  8  plaintext read data
ct_addr  output  8  ciphertext memory address
ct_wrdata  output  8  ciphertext write data
ct_wren  output  1  ciphertext write enable

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rdy=1, all addresses/wrdata=0, s_wren=ct_wren=0, i=j=k=L=0. Reset mid-operation aborts immediately; no further writes are issued.
- Memory timing: all outputs are registered. RAMs sample the address at the end of the cycle in which it is driven; read data is valid, and latched by this block, in the following cycle. Writes occur in the cycle wren=1.
- Start: en=1 with rdy=1 at a clock edge → rdy=0 next cycle, i=j=0, k=1. en while busy is ignored.
- Header states:
  - LEN_A: pt_addr=PT_BASE.
  - LEN_W: latch L=pt_rddata.
  - LEN_WR: ct_addr=CT_BASE, ct_wrdata=L, ct_wren=1.
  - Then go to B1 if L≠0, else to DONE.
- Per-byte states, exactly 9 cycles per byte, all arithmetic mod 256:
  - B1: i←i+1; s_addr=i+1; pt_addr=PT_BASE+k.
  - B2: si←s_rddata; ptb←pt_rddata.
  - B3: j←j+si; s_addr=j+si.
  - B4: sj←s_rddata.
  - B5: s_addr=j, s_wrdata=si, s_wren=1.
  - B6: s_addr=i, s_wrdata=sj, s_wren=1.
  - B7: s_addr=si+sj.
  - B8: pad←s_rddata.
  - B9: ct_addr=CT_BASE+k, ct_wrdata=ptb^pad, ct_wren=1. If k==L go to DONE, else k←k+1 and go to B1.
- DONE: all wren=0; return to IDLE with rdy=1.
- Latency: rdy returns high exactly 4+9L cycles after the accepting edge.
- Boundary conditions:
  - i==j: both swap writes target the same address and S is unchanged, since si==sj.
  - L=255: k counts to 255 without wrapping; ct addresses wrap mod 256 relative to CT_BASE.
- wren is never asserted outside B5/B6 (s_wren), LEN_WR/B9 (ct_wren), and never asserted in IDLE.

Optional Feature:
Macro PRGA_ENC_CHECKSUM_EN.
- When defined: adds output port ct_xsum[7:0].
  - Cleared to 0 on reset and on the start edge.
  - XOR-accumulates every ciphertext byte written in B9, excluding the length byte.
  - Stable and valid whenever rdy=1.
- When undefined: the port and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Identity S (S[x]=x), pt={01,00} → ct={01,02}; S[1] unchanged; rdy high 13 cycles after start.
2. Identity S, pt={02,00,00} → ct={02,02,05}; S[2]=03, S[3]=02; rdy at 22 cycles; with PRGA_ENC_CHECKSUM_EN, ct_xsum=07.
3. L=0 (pt={00}) → single write ct[0]=00, no s_wren pulses, rdy at 4 cycles.
4. KSA with key 0x000018, encrypt a 16-byte message, run the decryptor on the CT memory after re-running KSA → recovered plaintext equals the original.
5. rst_n pulled low during B5 of byte 3 → s_wren/ct_wren drop immediately, rdy=1, no later writes; a new en then completes correctly.
6. en held high throughout an operation → exactly one operation per rdy window; en during busy has no effect on outputs.

Source files
------------

// File: rtl/prga_enc.sv
// ARC4 keystream encryptor: length-prefixed PT in, length-prefixed CT out.
// Optional ct_xsum output enabled by defining PRGA_ENC_CHECKSUM_EN.
module prga_enc #(
  parameter logic [7:0] PT_BASE = 8'd0,
  parameter logic [7:0] CT_BASE = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
`ifdef PRGA_ENC_CHECKSUM_EN
  ,
  output logic [7:0] ct_xsum
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_A,
    LEN_W,
    LEN_WR,
    B1,
    B2,
    B3,
    B4,
    B5,
    B6,
    B7,
    B8,
    B9,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_q, rdy_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] ct_wrdata_q, ct_wrdata_d;
  logic       ct_wren_q, ct_wren_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] l_q, l_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ptb_q, ptb_d;
`ifdef PRGA_ENC_CHECKSUM_EN
  logic [7:0] xsum_q, xsum_d;
`endif

  // Outputs are registered, so each branch loads the values the next state presents.
  always_comb begin
    state_d     = state_q;
    rdy_d       = 1'b0;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    l_d         = l_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ptb_d       = ptb_q;
`ifdef PRGA_ENC_CHECKSUM_EN
    xsum_d      = xsum_q;
`endif
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (en) begin
          state_d   = LEN_A;
          rdy_d     = 1'b0;
          i_d       = 8'd0;
          j_d       = 8'd0;
          k_d       = 8'd1;
          pt_addr_d = PT_BASE;
`ifdef PRGA_ENC_CHECKSUM_EN
          xsum_d    = 8'd0;
`endif
        end
      end
      LEN_A: state_d = LEN_W;
      LEN_W: begin
        state_d     = LEN_WR;
        l_d         = pt_rddata;
        ct_addr_d   = CT_BASE;
        ct_wrdata_d = pt_rddata;
        ct_wren_d   = 1'b1;
      end
      LEN_WR: begin
        if (l_q != 8'd0) begin
          state_d   = B1;
          i_d       = i_q + 8'd1;
          s_addr_d  = i_q + 8'd1;
          pt_addr_d = PT_BASE + k_q;
        end else begin
          state_d = DONE;
        end
      end
      B1: state_d = B2;
      B2: begin
        state_d  = B3;
        si_d     = s_rddata;
        ptb_d    = pt_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
      end
      B3: state_d = B4;
      B4: begin
        state_d    = B5;
        sj_d       = s_rddata;
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
      end
      B5: begin
        state_d    = B6;
        s_addr_d   = i_q;
        s_wrdata_d = sj_q;
        s_wren_d   = 1'b1;
      end
      B6: begin
        state_d  = B7;
        s_addr_d = si_q + sj_q;
      end
      B7: state_d = B8;
      B8: begin
        state_d     = B9;
        ct_addr_d   = CT_BASE + k_q;
        ct_wrdata_d = ptb_q ^ s_rddata;
        ct_wren_d   = 1'b1;
`ifdef PRGA_ENC_CHECKSUM_EN
        xsum_d      = xsum_q ^ ptb_q ^ s_rddata;
`endif
      end
      B9: begin
        if (k_q == l_q) begin
          state_d = DONE;
        end else begin
          state_d   = B1;
          k_d       = k_q + 8'd1;
          i_d       = i_q + 8'd1;
          s_addr_d  = i_q + 8'd1;
          pt_addr_d = PT_BASE + k_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      l_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      ptb_q       <= 8'd0;
`ifdef PRGA_ENC_CHECKSUM_EN
      xsum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      l_q         <= l_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ptb_q       <= ptb_d;
`ifdef PRGA_ENC_CHECKSUM_EN
      xsum_q      <= xsum_d;
`endif
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;
`ifdef PRGA_ENC_CHECKSUM_EN
  assign ct_xsum   = xsum_q;
`endif

endmodule

// File: tb/tb_prga_enc.sv
// Bench for prga_enc: RAM models, ARC4 reference model, write-stream compare.
// Random S/plaintext plus literal pins for the small hand-worked cases.
module tb_prga_enc;

  localparam logic [7:0] PTB = 8'h10;
  localparam logic [7:0] CTB = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_wrdata, s_rd;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rd;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;
`ifdef PRGA_ENC_CHECKSUM_EN
  logic [7:0] ct_xsum;
`endif

  always #5 clk = ~clk;

  prga_enc #(.PT_BASE(PTB), .CT_BASE(CTB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rdy(rdy),
    .s_addr(s_addr),
    .s_rddata(s_rd),
    .s_wrdata(s_wrdata),
    .s_wren(s_wren),
    .pt_addr(pt_addr),
    .pt_rddata(pt_rd),
    .ct_addr(ct_addr),
    .ct_wrdata(ct_wrdata),
    .ct_wren(ct_wren)
`ifdef PRGA_ENC_CHECKSUM_EN
    ,
    .ct_xsum(ct_xsum)
`endif
  );

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem[256];
  logic [7:0] ct_mem[256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'd0;
  logic [7:0] bd_data = 8'd0;

  // Synchronous RAMs: address sampled at the edge, data out the next cycle.
  always @(posedge clk) begin
    if (bd_we) s_mem[bd_addr] <= bd_data;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rd  <= s_mem[s_addr];
    pt_rd <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  int total = 0;
  int bad = 0;
  logic [15:0] q_s[$];
  logic [15:0] q_ct[$];
  logic [15:0] e_s, e_ct;
  logic [7:0] s_img[256];
  logic [7:0] m_s[256];
  logic [7:0] exp_xs;
  int exp_lat;
  int last_lat;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ct_wren) begin
        if (q_ct.size() == 0) chk("ct_extra_write", 1, 0);
        else begin
          e_ct = q_ct.pop_front();
          chk("ct_write", {ct_addr, ct_wrdata}, e_ct);
        end
      end
      if (s_wren) begin
        if (q_s.size() == 0) chk("s_extra_write", 1, 0);
        else begin
          e_s = q_s.pop_front();
          chk("s_write", {s_addr, s_wrdata}, e_s);
        end
      end
      if (rdy) chk("idle_no_wren", {30'd0, s_wren, ct_wren}, 0);
    end
  end

  // Plain ARC4 PRGA over a snapshot of S and PT.
  task automatic build_model();
    logic [7:0] i, j, si, sj, pad, c, l;
    for (int a = 0; a < 256; a++) m_s[a] = s_mem[a];
    q_s.delete();
    q_ct.delete();
    l = pt_mem[PTB];
    q_ct.push_back({CTB, l});
    i = 0;
    j = 0;
    exp_xs = 0;
    for (int k = 1; k <= int'(l); k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      si = m_s[i];
      sj = m_s[j];
      q_s.push_back({j, si});
      q_s.push_back({i, sj});
      m_s[i] = sj;
      m_s[j] = si;
      pad = m_s[8'(si + sj)];
      c = pt_mem[8'(PTB + 8'(k))] ^ pad;
      q_ct.push_back({8'(CTB + 8'(k)), c});
      exp_xs = exp_xs ^ c;
    end
    exp_lat = 4 + 9 * int'(l);
  endtask

  task automatic load_s();
    for (int a = 0; a < 256; a++) begin
      bd_we = 1'b1;
      bd_addr = 8'(a);
      bd_data = s_img[a];
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;
  endtask

  task automatic ident_s();
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
  endtask

  task automatic shuffle_s();
    logic [7:0] t;
    int r;
    ident_s();
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = s_img[a];
      s_img[a] = s_img[r];
      s_img[r] = t;
    end
  endtask

  task automatic ksa(input logic [7:0] k0, input logic [7:0] k1,
                     input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] j, t;
    key[0] = k0;
    key[1] = k1;
    key[2] = k2;
    ident_s();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = j + s_img[i] + key[i % 3];
      t = s_img[i];
      s_img[i] = s_img[j];
      s_img[j] = t;
    end
  endtask

  task automatic rand_pt(input int l);
    pt_mem[PTB] = 8'(l);
    for (int a = 1; a <= l; a++) pt_mem[8'(PTB + 8'(a))] = 8'($urandom);
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input bit hold);
    int cnt, mism;
    build_model();
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    chk("rdy_drop", {31'd0, rdy}, 0);
    cnt = 0;
    while (!rdy && cnt < exp_lat + 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    en = 1'b0;
    last_lat = cnt;
    chk("latency", cnt, exp_lat);
    chk("ct_writes_left", q_ct.size(), 0);
    chk("s_writes_left", q_s.size(), 0);
    mism = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] != m_s[a]) mism++;
    chk("s_final", mism, 0);
`ifdef PRGA_ENC_CHECKSUM_EN
    chk("xsum", {24'd0, ct_xsum}, {24'd0, exp_xs});
`endif
    @(posedge clk);
    #1;
    chk("rdy_stays", {31'd0, rdy}, 1);
  endtask

  logic [7:0] msg[17];
  int mism;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, rdy}, 1);
    chk("rst_wren", {30'd0, s_wren, ct_wren}, 0);
    chk("rst_addr", {8'd0, s_addr, pt_addr, ct_addr}, 0);
    chk("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ident_s();
    load_s();
    pt_mem[PTB] = 8'h01;
    pt_mem[8'(PTB + 8'd1)] = 8'h00;
    run_op(1'b0);
    chk("t1_ct0", {24'd0, ct_mem[CTB]}, 8'h01);
    chk("t1_ct1", {24'd0, ct_mem[8'(CTB + 8'd1)]}, 8'h02);
    chk("t1_s1", {24'd0, s_mem[1]}, 8'h01);
    chk("t1_lat", last_lat, 13);

    ident_s();
    load_s();
    pt_mem[PTB] = 8'h02;
    pt_mem[8'(PTB + 8'd1)] = 8'h00;
    pt_mem[8'(PTB + 8'd2)] = 8'h00;
    run_op(1'b0);
    chk("t2_ct1", {24'd0, ct_mem[8'(CTB + 8'd1)]}, 8'h02);
    chk("t2_ct2", {24'd0, ct_mem[8'(CTB + 8'd2)]}, 8'h05);
    chk("t2_s2", {24'd0, s_mem[2]}, 8'h03);
    chk("t2_s3", {24'd0, s_mem[3]}, 8'h02);
    chk("t2_lat", last_lat, 22);
`ifdef PRGA_ENC_CHECKSUM_EN
    chk("t2_xsum", {24'd0, ct_xsum}, 8'h07);
`endif

    pt_mem[PTB] = 8'h00;
    run_op(1'b0);
    chk("t3_ct0", {24'd0, ct_mem[CTB]}, 8'h00);
    chk("t3_lat", last_lat, 4);

    ksa(8'h00, 8'h00, 8'h18);
    load_s();
    rand_pt(16);
    for (int a = 0; a <= 16; a++) msg[a] = pt_mem[8'(PTB + 8'(a))];
    run_op(1'b0);
    for (int a = 0; a <= 16; a++)
      pt_mem[8'(PTB + 8'(a))] = ct_mem[8'(CTB + 8'(a))];
    load_s();
    run_op(1'b0);
    mism = 0;
    for (int a = 0; a <= 16; a++)
      if (ct_mem[8'(CTB + 8'(a))] != msg[a]) mism++;
    chk("t4_roundtrip", mism, 0);

    shuffle_s();
    load_s();
    rand_pt(6);
    build_model();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("t5_in_b5", {31'd0, s_wren}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wren", {30'd0, s_wren, ct_wren}, 0);
    chk("t5_rst_rdy", {31'd0, rdy}, 1);
    q_s.delete();
    q_ct.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_pt(5);
    run_op(1'b0);

    shuffle_s();
    load_s();
    rand_pt(7);
    run_op(1'b1);

    for (int n = 0; n < 6; n++) begin
      shuffle_s();
      load_s();
      rand_pt($urandom_range(30, 1));
      run_op(n[0]);
    end

    shuffle_s();
    load_s();
    rand_pt(255);
    run_op(1'b0);
    chk("t_l255_lat", last_lat, 4 + 9 * 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
